// File: rtl/imem_loader_pkg.sv
// Shared encodings and FSM state constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int REG_W = 5;
    localparam int IMM_W = 16;
    localparam int TGT_W = 26;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDI  = 6'b001000,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opecode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } funct_t;

    typedef logic [1:0] loader_state_t;
    localparam loader_state_t ST_IDLE = 2'd0;
    localparam loader_state_t ST_LOAD = 2'd1;
    localparam loader_state_t ST_DONE = 2'd2;
    localparam loader_state_t ST_ERR  = 2'd3;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_SLT);
    endfunction

endpackage

// File: rtl/imem_loader_instr_pack.sv
// Combinational encoder: field tuple -> 32-bit MIPS word plus a legality flag.
module instr_pack
    import imem_loader_pkg::*;
(
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic [IMM_W-1:0] imm,
    input  logic [TGT_W-1:0] target,
    output logic [31:0]      word,
    output logic             legal
);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (op)
            OP_RTYPE: begin
                word  = {op, rs, rt, rd, 5'b00000, funct};
                legal = funct_legal(funct);
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: begin
                word  = {op, rs, rt, imm};
                legal = 1'b1;
            end
            OP_J: begin
                word  = {op, target};
                legal = 1'b1;
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// Streams encoded instructions into instruction memory, one word per accepted tuple.
// Optional running XOR of written words via IMEM_LOADER_CHECKSUM_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// LOAD    | accepting tuples and writing words
// DONE    | last tuple written, done sticky
// ERR     | illegal tuple or overflow, err sticky
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [5:0]             in_op,
    input  logic [5:0]             in_funct,
    input  logic [REG_W-1:0]       in_rs,
    input  logic [REG_W-1:0]       in_rt,
    input  logic [REG_W-1:0]       in_rd,
    input  logic [IMM_W-1:0]       in_imm,
    input  logic [TGT_W-1:0]       in_target,
    input  logic                   in_last,
    output logic                   imem_we,
    output logic [31:0]            imem_addr,
    output logic [31:0]            imem_wd,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   done,
    output logic                   err
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]            checksum
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    loader_state_t state;
    logic [31:0]   word;
    logic          legal;
    logic          accept;

    instr_pack u_pack (
        .op     (in_op),
        .funct  (in_funct),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .imm    (in_imm),
        .target (in_target),
        .word   (word),
        .legal  (legal)
    );

    assign in_ready = (state == ST_LOAD) && (count < CW'(DEPTH));
    assign busy     = (state == ST_LOAD);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            imem_we   <= 1'b0;
            imem_addr <= BASE_ADDR;
            imem_wd   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum  <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (legal) begin
                            imem_we   <= 1'b1;
                            imem_wd   <= word;
                            imem_addr <= BASE_ADDR + (32'(count) << 2);
                            count     <= count + 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            checksum  <= checksum ^ word;
`endif
                            // last wins over full: the DEPTH-th word may close the session
                            if (in_last) begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                        end
                    end else if (count == CW'(DEPTH)) begin
                        state <= ST_ERR;
                        err   <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        count    <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
